// File: rtl/uart_pkg.sv
// Shared constants for the uart_link serial peer: oversample ratio, FSM
// encodings and bit-period helpers used by both the TX and RX paths.
package uart_pkg;

    localparam int OVERSAMPLE         = 8;
    localparam int HALF_BIT           = OVERSAMPLE / 2;
    localparam int DATA_WIDTH_DEFAULT = 8;
    localparam int CNT_W              = 16 + $clog2(OVERSAMPLE);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    // A prescale of zero would stall the line forever, so it runs as one.
    function automatic logic [CNT_W-1:0] bit_cycles(input logic [15:0] prescale);
        logic [15:0] p;
        p = (prescale == 16'd0) ? 16'd1 : prescale;
        return CNT_W'(p) * CNT_W'(OVERSAMPLE);
    endfunction

    function automatic logic [CNT_W-1:0] half_cycles(input logic [15:0] prescale);
        logic [15:0] p;
        p = (prescale == 16'd0) ? 16'd1 : prescale;
        return CNT_W'(p) * CNT_W'(HALF_BIT);
    endfunction

endpackage

// File: rtl/uart_link_rx.sv
// Receive half of uart_link: synchronizes rxd, finds start edges, samples
// mid-bit and hands complete characters to a valid/ready consumer.
module uart_link_rx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [15:0]           prescale,
    input  logic                  rxd,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  rx_busy,
    output logic                  rx_overrun,
    output logic                  rx_frame_error
);

    localparam int BIT_W = $clog2(DATA_WIDTH + 1);

    logic                  rx_meta;
    logic                  rx_sync;
    logic                  rx_prev;
    logic [1:0]            state;
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      bit_len;
    logic [BIT_W-1:0]      bit_idx;
    logic [DATA_WIDTH-1:0] shift;
    logic                  cnt_zero;
    logic                  start_edge;
    logic                  stop_sample;
    logic                  byte_done;

    assign cnt_zero    = (cnt == '0);
    assign start_edge  = (state == ST_IDLE) && rx_prev && !rx_sync;
    assign stop_sample = (state == ST_STOP) && cnt_zero;
    assign byte_done   = stop_sample && rx_sync;
    assign rx_busy     = (state != ST_IDLE);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values; blocking here would collapse the sync chain.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rxd;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_edge) begin
                        state <= ST_START;
                        cnt   <= half_cycles(prescale) - CNT_W'(1);
                    end
                end
                ST_START: begin
                    if (cnt_zero) begin
                        // A line back high at mid-start was only a glitch.
                        if (rx_sync) begin
                            state <= ST_IDLE;
                        end else begin
                            state   <= ST_DATA;
                            cnt     <= bit_len - CNT_W'(1);
                            bit_idx <= '0;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (cnt_zero) begin
                        cnt <= bit_len - CNT_W'(1);
                        if (bit_idx == BIT_W'(DATA_WIDTH - 1)) begin
                            state <= ST_STOP;
                        end else begin
                            bit_idx <= bit_idx + BIT_W'(1);
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_STOP: begin
                    if (cnt_zero) begin
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // NOTE: pure datapath registers carry no reset; the FSM decides when
    // their contents matter, which keeps the reset tree small.
    always_ff @(posedge clk) begin
        if (start_edge) begin
            bit_len <= bit_cycles(prescale);
        end
        if (state == ST_DATA && cnt_zero) begin
            shift <= {rx_sync, shift[DATA_WIDTH-1:1]};
        end
    end

    // A fresh byte wins over a consumer pop in the same cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            m_data         <= '0;
            m_valid        <= 1'b0;
            rx_overrun     <= 1'b0;
            rx_frame_error <= 1'b0;
        end else begin
            if (byte_done) begin
                m_data  <= shift;
                m_valid <= 1'b1;
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
            rx_overrun     <= byte_done && m_valid && !m_ready;
            rx_frame_error <= stop_sample && !rx_sync;
        end
    end

endmodule

// File: rtl/uart_link.sv
// Serial-line peer of the SoC UART: inline 8N1 transmitter plus the
// uart_link_rx receiver, running fully independently of each other.
module uart_link
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [15:0]           prescale,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  txd,
    input  logic                  rxd,
    output logic                  tx_busy,
    output logic                  rx_busy,
    output logic                  rx_overrun,
    output logic                  rx_frame_error
);

    localparam int BIT_W = $clog2(DATA_WIDTH + 1);

    logic [1:0]            tx_state;
    logic [CNT_W-1:0]      tx_cnt;
    logic [CNT_W-1:0]      tx_bit_len;
    logic [BIT_W-1:0]      tx_idx;
    logic [DATA_WIDTH-1:0] tx_shift;
    logic [DATA_WIDTH-1:0] tx_next;
    logic                  tx_cnt_zero;
    logic                  tx_accept;
    logic                  txd_q;

    assign tx_cnt_zero = (tx_cnt == '0);
    assign tx_accept   = (tx_state == ST_IDLE) && s_valid;
    assign tx_next     = tx_shift >> 1;
    assign s_ready     = (tx_state == ST_IDLE);
    assign tx_busy     = !s_ready;
    assign txd         = txd_q;

    // txd is registered so the line never glitches between bit periods.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tx_state <= ST_IDLE;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            txd_q    <= 1'b1;
        end else begin
            case (tx_state)
                ST_IDLE: begin
                    if (s_valid) begin
                        tx_state <= ST_START;
                        txd_q    <= 1'b0;
                        tx_cnt   <= bit_cycles(prescale) - CNT_W'(1);
                    end
                end
                ST_START: begin
                    if (tx_cnt_zero) begin
                        tx_state <= ST_DATA;
                        txd_q    <= tx_shift[0];
                        tx_cnt   <= tx_bit_len - CNT_W'(1);
                        tx_idx   <= '0;
                    end else begin
                        tx_cnt <= tx_cnt - CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (tx_cnt_zero) begin
                        tx_cnt <= tx_bit_len - CNT_W'(1);
                        if (tx_idx == BIT_W'(DATA_WIDTH - 1)) begin
                            tx_state <= ST_STOP;
                            txd_q    <= 1'b1;
                        end else begin
                            tx_idx <= tx_idx + BIT_W'(1);
                            txd_q  <= tx_next[0];
                        end
                    end else begin
                        tx_cnt <= tx_cnt - CNT_W'(1);
                    end
                end
                ST_STOP: begin
                    if (tx_cnt_zero) begin
                        tx_state <= ST_IDLE;
                    end else begin
                        tx_cnt <= tx_cnt - CNT_W'(1);
                    end
                end
                default: tx_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (tx_accept) begin
            tx_shift   <= s_data;
            tx_bit_len <= bit_cycles(prescale);
        end else if (tx_state == ST_DATA && tx_cnt_zero) begin
            tx_shift <= tx_next;
        end
    end

    uart_link_rx #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rx (
        .clk            (clk),
        .reset_n        (reset_n),
        .prescale       (prescale),
        .rxd            (rxd),
        .m_data         (m_data),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .rx_busy        (rx_busy),
        .rx_overrun     (rx_overrun),
        .rx_frame_error (rx_frame_error)
    );

endmodule

// File: tb/tb_uart_link.sv
// Directed bench for uart_link: TX waveform, loopback, RX error paths,
// glitch rejection and mid-frame reset, with a queue of expected RX bytes.
module tb_uart_link;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] prescale = 16'd1;
    logic [7:0]  s_data = 8'h00;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic        txd;
    logic        rxd;
    logic        rxd_drv = 1'b1;
    logic        loopback = 1'b0;
    logic        tx_busy;
    logic        rx_busy;
    logic        rx_overrun;
    logic        rx_frame_error;

    assign rxd = loopback ? txd : rxd_drv;

    uart_link #(.DATA_WIDTH(8)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .prescale       (prescale),
        .s_data         (s_data),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .m_data         (m_data),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .txd            (txd),
        .rxd            (rxd),
        .tx_busy        (tx_busy),
        .rx_busy        (rx_busy),
        .rx_overrun     (rx_overrun),
        .rx_frame_error (rx_frame_error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    int   delivered = 0;
    int   fe_cycles = 0;
    int   fe_pulses = 0;
    int   ov_cycles = 0;
    int   ov_pulses = 0;
    logic fe_prev = 1'b0;
    logic ov_prev = 1'b0;
    logic mv_seen = 1'b0;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Sampled on the falling edge, half a cycle clear of the active edge.
    always @(negedge clk) begin
        if (m_valid && m_ready) begin
            delivered++;
            if (exp_q.size() == 0) begin
                check("rx_unexpected_byte", {24'd0, m_data}, 32'hFFFF_FFFF);
            end else begin
                check("rx_data", {24'd0, m_data}, {24'd0, exp_q.pop_front()});
            end
        end
        if (rx_frame_error) fe_cycles++;
        if (rx_frame_error && !fe_prev) fe_pulses++;
        if (rx_overrun) ov_cycles++;
        if (rx_overrun && !ov_prev) ov_pulses++;
        fe_prev = rx_frame_error;
        ov_prev = rx_overrun;
        if (m_valid) mv_seen = 1'b1;
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        while (!s_ready && t < 4000) begin
            cycles(1);
            t++;
        end
        if (t >= 4000) check("tx_ready_timeout", 32'd0, 32'd1);
        s_data  = b;
        s_valid = 1'b1;
        cycles(1);
        s_valid = 1'b0;
    endtask

    task automatic rx_frame(input logic [7:0] b, input logic stop_bit, input int p);
        logic [9:0] frame;
        frame = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rxd_drv = frame[i];
            cycles(p * 8);
        end
        rxd_drv = 1'b1;
        cycles(p * 8);
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < budget) begin
            cycles(1);
            t++;
        end
        check(tag, exp_q.size(), 32'd0);
    endtask

    task automatic measure_ready_low(input string tag, input logic [7:0] b, input int expect_len);
        int low;
        low = 0;
        send_byte(b);
        while (!s_ready && low < 2000) begin
            @(negedge clk);
            if (!s_ready) low++;
        end
        check(tag, low, expect_len);
        cycles(1);
    endtask

    initial begin
        logic [9:0] frame;
        int bad;
        int low;
        int d0;

        // Reset state
        reset_n = 1'b0;
        cycles(3);
        check("rst_txd", {31'd0, txd}, 32'd1);
        check("rst_s_ready", {31'd0, s_ready}, 32'd1);
        check("rst_tx_busy", {31'd0, tx_busy}, 32'd0);
        check("rst_rx_busy", {31'd0, rx_busy}, 32'd0);
        check("rst_m_valid", {31'd0, m_valid}, 32'd0);
        check("rst_m_data", {24'd0, m_data}, 32'd0);
        check("rst_overrun", {31'd0, rx_overrun}, 32'd0);
        check("rst_frame_err", {31'd0, rx_frame_error}, 32'd0);
        reset_n = 1'b1;
        cycles(2);

        // TX waveform of 0x55 at prescale 1
        prescale = 16'd1;
        s_data   = 8'h55;
        s_valid  = 1'b1;
        cycles(1);
        s_valid  = 1'b0;
        frame    = {1'b1, 8'h55, 1'b0};
        low      = 0;
        for (int b = 0; b < 10; b++) begin
            bad = 0;
            for (int c = 0; c < 8; c++) begin
                @(negedge clk);
                if (txd !== frame[b]) bad++;
                if (!s_ready) low++;
            end
            check($sformatf("tx55_bit%0d_mismatches", b), bad, 32'd0);
        end
        @(negedge clk);
        if (!s_ready) low++;
        check("tx55_ready_low_cycles", low, 32'd80);
        check("tx55_idle_txd", {31'd0, txd}, 32'd1);
        cycles(1);

        // Prescale 0 behaves as 1
        prescale = 16'd0;
        measure_ready_low("tx_prescale0_len", 8'h3A, 80);

        // Loopback at prescale 2
        prescale = 16'd2;
        loopback = 1'b1;
        m_ready  = 1'b1;
        d0       = delivered;
        exp_q.push_back(8'hA5);
        send_byte(8'hA5);
        exp_q.push_back(8'h3C);
        send_byte(8'h3C);
        wait_drain("loop_drain", 3000);
        check("loop_count", delivered - d0, 32'd2);
        cycles(5);
        check("loop_m_valid_clear", {31'd0, m_valid}, 32'd0);
        loopback = 1'b0;
        cycles(20);

        // Frame error: 0x81 with a low stop bit
        fe_cycles = 0;
        fe_pulses = 0;
        mv_seen   = 1'b0;
        rx_frame(8'h81, 1'b0, 2);
        cycles(10);
        check("fe_pulses", fe_pulses, 32'd1);
        check("fe_pulse_width", fe_cycles, 32'd1);
        check("fe_no_m_valid", {31'd0, mv_seen}, 32'd0);

        // Overrun: two bytes with no consumer
        m_ready   = 1'b0;
        ov_cycles = 0;
        ov_pulses = 0;
        exp_q.push_back(8'h11);
        rx_frame(8'h11, 1'b1, 2);
        check("ov_first_valid", {31'd0, m_valid}, 32'd1);
        check("ov_first_data", {24'd0, m_data}, 32'h11);
        check("ov_no_early_pulse", ov_pulses, 32'd0);
        exp_q.push_back(8'h22);
        rx_frame(8'h22, 1'b1, 2);
        check("ov_pulses", ov_pulses, 32'd1);
        check("ov_pulse_width", ov_cycles, 32'd1);
        check("ov_second_data", {24'd0, m_data}, 32'h22);
        check("ov_second_valid", {31'd0, m_valid}, 32'd1);
        void'(exp_q.pop_front());
        m_ready = 1'b1;
        cycles(3);
        check("ov_drain", exp_q.size(), 32'd0);
        check("ov_m_valid_clear", {31'd0, m_valid}, 32'd0);

        // Two-cycle low glitch at prescale 1
        prescale = 16'd1;
        mv_seen  = 1'b0;
        rxd_drv  = 1'b0;
        cycles(2);
        rxd_drv  = 1'b1;
        cycles(1);
        check("glitch_start_seen", {31'd0, rx_busy}, 32'd1);
        cycles(5);
        check("glitch_rx_idle", {31'd0, rx_busy}, 32'd0);
        cycles(20);
        check("glitch_no_m_valid", {31'd0, mv_seen}, 32'd0);

        // Reset in the middle of transmitting 0xF0
        loopback = 1'b1;
        d0       = delivered;
        send_byte(8'hF0);
        cycles(30);
        reset_n = 1'b0;
        cycles(1);
        reset_n = 1'b1;
        check("mid_rst_txd", {31'd0, txd}, 32'd1);
        check("mid_rst_s_ready", {31'd0, s_ready}, 32'd1);
        check("mid_rst_m_valid", {31'd0, m_valid}, 32'd0);
        exp_q.push_back(8'h0F);
        send_byte(8'h0F);
        wait_drain("mid_rst_drain", 2000);
        cycles(5);
        check("mid_rst_count", delivered - d0, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
